dino_jump_ctrl: RTL and testbench

- Per-frame sprite-position controller for the dinosaur.
- Accepts a jump request and advances a rise/fall physics state machine once per video frame, timed by the frame-end pulse from the VGA timing generator.
- Drives the x_coor/y_coor inputs of the VGA controller; y_coor is the sprite's bottom edge.
- Sits between the PS/2 key decode and the VGA controller.

---
 rtl/dino_pkg.sv | 37 +++
 rtl/dino_jump_ctrl_sync_edge.sv | 38 +++
 rtl/dino_jump_ctrl.sv | 146 ++++++++++++++
 tb/tb_dino_jump_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types and default constants for the dinosaur jump controller.
package dino_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    LAND   = 2'd3
  } dino_state_t;

  localparam int unsigned HEIGHT_W = 12;
  localparam int unsigned VEL_W    = 8;

  localparam int unsigned DEF_GROUND_Y    = 400;
  localparam int unsigned DEF_DINO_X      = 80;
  localparam int unsigned DEF_JUMP_V      = 20;
  localparam int unsigned DEF_GRAVITY     = 1;
  localparam int unsigned DEF_MAX_FALL    = 20;
  localparam int unsigned DEF_LAND_FRAMES = 2;

  // Apex height reached by the rise phase: sum of launch velocity and each
  // decremented velocity while it stays positive.
  function automatic int peak_height(input int jump_v, input int gravity);
    int h;
    int v;
    h = 0;
    v = jump_v;
    for (int unsigned i = 0; i < 256; i++) begin
      if (v > 0) begin
        h = h + v;
        v = v - gravity;
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/dino_jump_ctrl_sync_edge.sv
// Optional two-flop synchronizer followed by a rising-edge pulse generator.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic level;
  logic prev;

  if (STAGES != 0 && STAGES != 2) begin : g_bad_stages
    $error("sync_edge: STAGES must be 0 or 2");
  end

  if (STAGES == 0) begin : g_direct
    assign level = d;
  end else begin : g_sync
    logic [1:0] sync_q;
    // Two-stage metastability guard for the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], d};
    end
    assign level = sync_q[1];
  end

  // Previous level, used to spot the 0->1 transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/dino_jump_ctrl.sv
// Per-frame rise/fall physics for the dinosaur sprite; drives VGA x/y coordinates.
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned GROUND_Y    = DEF_GROUND_Y,
  parameter int unsigned DINO_X      = DEF_DINO_X,
  parameter int unsigned JUMP_V      = DEF_JUMP_V,
  parameter int unsigned GRAVITY     = DEF_GRAVITY,
  parameter int unsigned MAX_FALL    = DEF_MAX_FALL,
  parameter int unsigned LAND_FRAMES = DEF_LAND_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic        jump_btn,
  input  logic        pause,
  output logic [31:0] x_coor,
  output logic [31:0] y_coor,
  output logic        airborne,
  output logic [15:0] jump_count
);

  if (JUMP_V < 1 || JUMP_V > 127) begin : g_bad_jump_v
    $error("dino_jump_ctrl: JUMP_V out of range 1..127");
  end
  if (GRAVITY < 1 || GRAVITY > JUMP_V) begin : g_bad_gravity
    $error("dino_jump_ctrl: GRAVITY out of range 1..JUMP_V");
  end
  if (MAX_FALL < GRAVITY || MAX_FALL > 127) begin : g_bad_max_fall
    $error("dino_jump_ctrl: MAX_FALL must be GRAVITY..127");
  end
  if (LAND_FRAMES > 15) begin : g_bad_land
    $error("dino_jump_ctrl: LAND_FRAMES out of range 0..15");
  end
  if (peak_height(int'(JUMP_V), int'(GRAVITY)) >= int'(GROUND_Y)) begin : g_bad_peak
    $error("dino_jump_ctrl: jump peak reaches or exceeds GROUND_Y");
  end

  localparam logic        [HEIGHT_W-1:0] GROUND_Y_H = HEIGHT_W'(GROUND_Y);
  localparam logic signed [VEL_W-1:0]    JUMP_V_S   = VEL_W'(JUMP_V);
  localparam logic signed [VEL_W-1:0]    GRAV_S     = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0]    MAX_FALL_S = VEL_W'(MAX_FALL);
  localparam logic        [3:0]          LAND_INIT  = 4'(LAND_FRAMES);

  dino_state_t                state;
  logic        [HEIGHT_W-1:0] height;
  logic signed [VEL_W-1:0]    vel;
  logic signed [VEL_W-1:0]    fall_v;
  logic        [3:0]          land_cnt;
  logic                       pending;
  logic        [15:0]         jump_cnt_q;

  logic                       press;
  logic                       frame_edge;
  logic                       tick;
  logic signed [VEL_W-1:0]    vel_dec;
  logic        [VEL_W:0]      fv_sum;
  logic signed [VEL_W-1:0]    fv;
  logic        [HEIGHT_W-1:0] vel_ext;
  logic        [HEIGHT_W-1:0] fv_ext;

  sync_edge #(.STAGES(2)) u_jump_edge (
    .clk   (clk),
    .rst   (reset),
    .d     (jump_btn),
    .pulse (press)
  );

  sync_edge #(.STAGES(0)) u_frame_edge (
    .clk   (clk),
    .rst   (reset),
    .d     (screenEnd),
    .pulse (frame_edge)
  );

  assign tick = frame_edge & ~pause;

  // Next-step velocity arithmetic; fall_v and GRAVITY are never negative
  always_comb begin
    vel_dec = vel - GRAV_S;
    fv_sum  = {1'b0, fall_v} + {1'b0, GRAV_S};
    if (fv_sum > {1'b0, MAX_FALL_S}) fv = MAX_FALL_S;
    else                             fv = fv_sum[VEL_W-1:0];
    vel_ext = {{(HEIGHT_W-VEL_W){1'b0}}, vel};
    fv_ext  = {{(HEIGHT_W-VEL_W){1'b0}}, fv};
  end

  // Jump state machine, advanced once per unpaused frame tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= GROUND;
      height     <= '0;
      vel        <= '0;
      fall_v     <= '0;
      land_cnt   <= '0;
      pending    <= 1'b0;
      jump_cnt_q <= '0;
      airborne   <= 1'b0;
    end else begin
      if (press && (state == GROUND || state == LAND)) pending <= 1'b1;
      if (tick) begin
        unique case (state)
          // press is ORed in so a press coinciding with the tick still
          // launches; the later pending clear overrides the set above
          GROUND: begin
            if (pending || press) begin
              vel      <= JUMP_V_S;
              pending  <= 1'b0;
              state    <= RISE;
              airborne <= 1'b1;
              if (jump_cnt_q != '1) jump_cnt_q <= jump_cnt_q + 16'd1;
            end
          end
          RISE: begin
            height <= height + vel_ext;
            vel    <= vel_dec;
            if (vel_dec <= 8'sd0) begin
              fall_v <= '0;
              state  <= FALL;
            end
          end
          FALL: begin
            if (height <= fv_ext) begin
              height   <= '0;
              land_cnt <= LAND_INIT;
              state    <= LAND;
              airborne <= 1'b0;
            end else begin
              height <= height - fv_ext;
              fall_v <= fv;
            end
          end
          LAND: begin
            if (land_cnt == '0) state <= GROUND;
            else                land_cnt <= land_cnt - 4'd1;
          end
        endcase
      end
    end
  end

  assign jump_count = jump_cnt_q;
  assign x_coor     = 32'(DINO_X);
  assign y_coor     = {20'b0, GROUND_Y_H - height};

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Self-checking bench for dino_jump_ctrl: scoreboarded per-frame sprite position.
module tb_dino_jump_ctrl;

  localparam int GY = 400;

  typedef struct {
    int y;
    bit air;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        screenEnd;
  logic        jump_btn;
  logic        pause;
  logic [31:0] xa, ya, xb, yb, xc, yc;
  logic        aa, ab, ac;
  logic [15:0] ca, cb, cc;

  int errors = 0;
  int checks = 0;
  int sel    = 0;
  exp_t sb[$];

  // Reference physics state
  int m_st, m_h, m_v, m_fv, m_lc, m_pend, m_cnt;
  int m_jv = 20, m_g = 1, m_mf = 20;

  always #5 clk = ~clk;

  dino_jump_ctrl dut_a (
    .clk(clk), .reset(reset), .screenEnd(screenEnd), .jump_btn(jump_btn), .pause(pause),
    .x_coor(xa), .y_coor(ya), .airborne(aa), .jump_count(ca)
  );

  dino_jump_ctrl #(.JUMP_V(4)) dut_b (
    .clk(clk), .reset(reset), .screenEnd(screenEnd), .jump_btn(jump_btn), .pause(pause),
    .x_coor(xb), .y_coor(yb), .airborne(ab), .jump_count(cb)
  );

  dino_jump_ctrl #(.JUMP_V(5), .GRAVITY(2)) dut_c (
    .clk(clk), .reset(reset), .screenEnd(screenEnd), .jump_btn(jump_btn), .pause(pause),
    .x_coor(xc), .y_coor(yc), .airborne(ac), .jump_count(cc)
  );

  task automatic model_reset();
    m_st = 0; m_h = 0; m_v = 0; m_fv = 0; m_lc = 0; m_pend = 0; m_cnt = 0;
  endtask

  task automatic model_press();
    if (m_st == 0 || m_st == 3) m_pend = 1;
  endtask

  task automatic model_tick();
    int nf;
    if (pause) return;
    case (m_st)
      0: if (m_pend != 0) begin
        m_v = m_jv; m_pend = 0; m_st = 1;
        if (m_cnt < 65535) m_cnt++;
      end
      1: begin
        m_h = m_h + m_v;
        m_v = m_v - m_g;
        if (m_v <= 0) begin m_fv = 0; m_st = 2; end
      end
      2: begin
        nf = m_fv + m_g;
        if (nf > m_mf) nf = m_mf;
        if (m_h <= nf) begin m_h = 0; m_lc = 2; m_st = 3; end
        else begin m_h = m_h - nf; m_fv = nf; end
      end
      default: if (m_lc == 0) m_st = 0; else m_lc--;
    endcase
  endtask

  task automatic do_reset(input int jv, input int g, input int s);
    @(negedge clk);
    reset = 1'b1; screenEnd = 1'b0; jump_btn = 1'b0; pause = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    m_jv = jv; m_g = g; sel = s;
    sb.delete();
    @(negedge clk);
  endtask

  // Press pulse reaches the FSM 3 edges after the pin; model follows afterwards
  task automatic press();
    @(negedge clk); jump_btn = 1'b1;
    repeat (4) @(negedge clk);
    model_press();
    jump_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One frame: push expectation, pulse screenEnd for 4 cycles, pop and compare
  task automatic frame(output int obs_y, output bit obs_air);
    exp_t        e;
    logic [31:0] y;
    logic        a;
    logic [15:0] c;
    model_tick();
    e.y = GY - m_h; e.air = (m_st == 1 || m_st == 2); e.cnt = m_cnt;
    sb.push_back(e);
    @(negedge clk); screenEnd = 1'b1;
    @(negedge clk);
    case (sel)
      0:       begin y = ya; a = aa; c = ca; end
      1:       begin y = yb; a = ab; c = cb; end
      default: begin y = yc; a = ac; c = cc; end
    endcase
    e = sb.pop_front();
    checks++;
    if (y !== 32'(e.y)) begin
      errors++; $display("FAIL frame_y: got %0d expected %0d", y, e.y);
    end
    checks++;
    if (a !== e.air) begin
      errors++; $display("FAIL frame_airborne: got %0b expected %0b", a, e.air);
    end
    checks++;
    if (c !== 16'(e.cnt)) begin
      errors++; $display("FAIL frame_jump_count: got %0d expected %0d", c, e.cnt);
    end
    obs_y = int'(y); obs_air = a;
    repeat (3) @(negedge clk);
    screenEnd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic jump_cycle();
    int oy; bit oa; int n;
    press();
    n = 0;
    frame(oy, oa); n++;
    while (m_st != 0 && n < 100) begin frame(oy, oa); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL jump_cycle_bound: got %0d frames expected <100", n); end
  endtask

  task automatic test_reset();
    int oy; bit oa; int n;
    reset = 1'b1; screenEnd = 1'b0; jump_btn = 1'b0; pause = 1'b0;
    #3;
    checks++;
    if (ya !== 32'd400 || xa !== 32'd80 || aa !== 1'b0 || ca !== 16'd0) begin
      errors++; $display("FAIL reset_a: got y=%0d x=%0d air=%0b cnt=%0d expected 400 80 0 0", ya, xa, aa, ca);
    end
    checks++;
    if (yb !== 32'd400 || ab !== 1'b0 || cb !== 16'd0) begin
      errors++; $display("FAIL reset_b: got y=%0d air=%0b cnt=%0d expected 400 0 0", yb, ab, cb);
    end
    do_reset(20, 1, 0);
    press();
    n = 0;
    while (m_st != 2 && n < 60) begin frame(oy, oa); n++; end
    frame(oy, oa); frame(oy, oa);
    // Async assertion between edges
    @(posedge clk); #2 reset = 1'b1; #1;
    checks++;
    if (ya !== 32'd400 || aa !== 1'b0 || ca !== 16'd0) begin
      errors++; $display("FAIL reset_async: got y=%0d air=%0b cnt=%0d expected 400 0 0", ya, aa, ca);
    end
    @(negedge clk); screenEnd = 1'b1;
    repeat (4) @(negedge clk); screenEnd = 1'b0;
    @(negedge clk);
    checks++;
    if (ya !== 32'd400 || aa !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got y=%0d air=%0b expected 400 0", ya, aa);
    end
    reset = 1'b0;
    model_reset();
    // Pending request set while paused is discarded by reset
    pause = 1'b1; press(); pause = 1'b0;
    @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
    model_reset();
    frame(oy, oa);
    checks++;
    if (oa !== 1'b0) begin errors++; $display("FAIL reset_pending_lost: got air=%0b expected 0", oa); end
  endtask

  task automatic test_profile_small();
    int oy; bit oa;
    int exp_y[12] = '{400, 396, 393, 391, 390, 391, 393, 396, 400, 400, 400, 400};
    do_reset(4, 1, 1);
    press();
    for (int i = 0; i < 12; i++) begin
      frame(oy, oa);
      checks++;
      if (oy != exp_y[i]) begin
        errors++; $display("FAIL profile_y[%0d]: got %0d expected %0d", i, oy, exp_y[i]);
      end
      if (i == 7 || i == 8) begin
        checks++;
        if (oa !== (i == 7)) begin
          errors++; $display("FAIL profile_air[%0d]: got %0b expected %0b", i, oa, (i == 7));
        end
      end
    end
    checks++;
    if (cb !== 16'd1) begin errors++; $display("FAIL profile_count: got %0d expected 1", cb); end
  endtask

  task automatic test_default_jump();
    int oy; bit oa; int miny; int maxy;
    do_reset(20, 1, 0);
    press();
    miny = 1000; maxy = 0;
    for (int i = 0; i < 46; i++) begin
      frame(oy, oa);
      if (oy < miny) miny = oy;
      if (oy > maxy) maxy = oy;
    end
    checks++;
    if (miny != 190) begin errors++; $display("FAIL default_peak: got %0d expected 190", miny); end
    checks++;
    if (maxy != 400 || ya !== 32'd400) begin
      errors++; $display("FAIL default_land: got max=%0d final=%0d expected 400 400", maxy, ya);
    end
  endtask

  task automatic test_overshoot_land();
    int oy; bit oa;
    int exp_y[8] = '{400, 395, 392, 391, 393, 397, 400, 400};
    do_reset(5, 2, 2);
    press();
    for (int i = 0; i < 8; i++) begin
      frame(oy, oa);
      checks++;
      if (oy != exp_y[i]) begin
        errors++; $display("FAIL overshoot_y[%0d]: got %0d expected %0d", i, oy, exp_y[i]);
      end
    end
  endtask

  task automatic test_no_double_jump();
    int oy; bit oa; int n;
    do_reset(20, 1, 0);
    press();
    frame(oy, oa); frame(oy, oa); frame(oy, oa);
    press();
    n = 0;
    while (m_st != 3 && n < 100) begin frame(oy, oa); n++; end
    checks++;
    if (ca !== 16'd1 || n >= 100) begin
      errors++; $display("FAIL rise_press_dropped: got cnt=%0d frames=%0d expected 1 <100", ca, n);
    end
    press();
    for (int k = 1; k <= 4; k++) begin
      frame(oy, oa);
      checks++;
      if (oa !== (k == 4)) begin
        errors++; $display("FAIL land_press_launch[%0d]: got air=%0b expected %0b", k, oa, (k == 4));
      end
    end
    checks++;
    if (ca !== 16'd2) begin errors++; $display("FAIL land_press_count: got %0d expected 2", ca); end
  endtask

  task automatic test_pause();
    int oy; bit oa; int held; int n;
    do_reset(20, 1, 0);
    press();
    for (int i = 0; i < 6; i++) frame(oy, oa);
    held = oy;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame(oy, oa);
      checks++;
      if (oy != held) begin errors++; $display("FAIL pause_frozen[%0d]: got %0d expected %0d", i, oy, held); end
    end
    pause = 1'b0;
    n = 0;
    while (m_st != 0 && n < 100) begin frame(oy, oa); n++; end
    pause = 1'b1;
    press();
    frame(oy, oa);
    checks++;
    if (oa !== 1'b0) begin errors++; $display("FAIL pause_no_launch: got air=%0b expected 0", oa); end
    pause = 1'b0;
    frame(oy, oa);
    checks++;
    if (oa !== 1'b1 || ca !== 16'd2) begin
      errors++; $display("FAIL pause_press_launch: got air=%0b cnt=%0d expected 1 2", oa, ca);
    end
  endtask

  task automatic test_saturate();
    do_reset(20, 1, 0);
    force dut_a.jump_cnt_q = 16'hFFFE;
    #1 release dut_a.jump_cnt_q;
    m_cnt = 65534;
    for (int j = 0; j < 3; j++) begin
      jump_cycle();
      checks++;
      if (ca !== 16'hFFFF) begin
        errors++; $display("FAIL saturate[%0d]: got %h expected ffff", j, ca);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_profile_small();
    test_default_jump();
    test_overshoot_land();
    test_no_double_jump();
    test_pause();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
